// File: rtl/inst_queue_pkg.sv
// Shared fetch-to-decode definitions: bundle width, field offsets and a packing helper.
package inst_queue_pkg;

  localparam int FS_TO_DS_BUS_W = 64;
  localparam int PC_MSB         = 63;
  localparam int PC_LSB         = 32;
  localparam int INST_MSB       = 31;
  localparam int INST_LSB       = 0;

  typedef struct packed {
    logic [PC_MSB-PC_LSB:0]     pc;
    logic [INST_MSB-INST_LSB:0] inst;
  } fs_bundle_t;

  // Pack a pc/inst pair into the flat bus layout used between IF and ID.
  function automatic logic [FS_TO_DS_BUS_W-1:0] mk_bundle(input logic [31:0] pc,
                                                           input logic [31:0] inst);
    fs_bundle_t b;
    b.pc   = pc;
    b.inst = inst;
    return b;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// IF -> queue -> ID handshake bundle. The queue takes the slave side; the
// surrounding stages (or a bench) take the master side.
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int BUS_W = FS_TO_DS_BUS_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             in_valid;
  logic [BUS_W-1:0] in_bus;
  logic             in_allowin;
  logic             out_valid;
  logic [BUS_W-1:0] out_bus;
  logic             out_allowin;
  logic             flush;
  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, in_bus, out_allowin, flush,
    output in_allowin, out_valid, out_bus, count
  );

  modport master (
    output in_valid, in_bus, out_allowin, flush,
    input  in_allowin, out_valid, out_bus, count
  );
endinterface

// File: rtl/inst_queue.sv
// Circular FIFO of fetch bundles decoupling IF from ID. Output is a
// combinational read of registered storage, so a push is visible one cycle
// later; in_allowin depends only on occupancy, never on out_allowin.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int BUS_W = FS_TO_DS_BUS_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic         clk,
  input logic         resetn,
  inst_queue_if.slave q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [BUS_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_allowin;
  logic w_valid;
  logic w_push;
  logic w_pop;

  assign w_allowin = (r_count != FULL_CNT);
  assign w_valid   = (r_count != '0);
  assign w_push    = q.in_valid & w_allowin & ~q.flush;
  assign w_pop     = w_valid & q.out_allowin & ~q.flush;

  assign q.in_allowin = w_allowin;
  assign q.out_valid  = w_valid;
  assign q.out_bus    = r_mem[r_rd_ptr];
  assign q.count      = r_count;

  // Pointer and occupancy update; flush rewinds everything but leaves entries intact.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (q.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; reset zeroes every entry so the empty queue shows 0 on out_bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= q.in_bus;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill, drain, streaming with wrap,
// flush and asynchronous reset, checked with immediate assertions.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int BUS_W = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  inst_queue_if #(.BUS_W(BUS_W), .DEPTH(DEPTH)) q ();

  inst_queue #(.BUS_W(BUS_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    q.in_valid    = 1'b0;
    q.in_bus      = '0;
    q.out_allowin = 1'b0;
    q.flush       = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    step();
    check("rst_count",   64'(q.count), 64'd0);
    check("rst_ovalid",  64'(q.out_valid), 64'd0);
    check("rst_allowin", 64'(q.in_allowin), 64'd1);
    check("rst_obus",    q.out_bus, 64'd0);

    // Fill to full with ID stalled
    q.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.in_bus = mk_bundle(32'h1c000000 + 32'(4*i), 32'hA0 + 32'(i));
      check("fill_allowin", 64'(q.in_allowin), 64'd1);
      step();
      check("fill_count", 64'(q.count), 64'(i + 1));
      check("fill_ovalid", 64'(q.out_valid), 64'd1);
    end
    check("full_allowin", 64'(q.in_allowin), 64'd0);
    q.in_bus = mk_bundle(32'h1c000010, 32'hA4);
    step();
    check("full_count", 64'(q.count), 64'd4);
    check("full_head", q.out_bus, mk_bundle(32'h1c000000, 32'hA0));
    q.in_valid = 1'b0;

    // Drain in order
    q.out_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_ovalid", 64'(q.out_valid), 64'd1);
      check("drain_obus", q.out_bus, mk_bundle(32'h1c000000 + 32'(4*i), 32'hA0 + 32'(i)));
      step();
      if (i == 0) check("drain_allowin", 64'(q.in_allowin), 64'd1);
    end
    check("drain_ovalid_end", 64'(q.out_valid), 64'd0);
    check("drain_count_end", 64'(q.count), 64'd0);

    // Simultaneous push and pop with pointer wrap
    q.out_allowin = 1'b0;
    q.in_valid    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q.in_bus = mk_bundle(32'h2000 + 32'(i), 32'hC0 + 32'(i));
      step();
    end
    check("stream_pre_count", 64'(q.count), 64'd2);
    q.out_allowin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q.in_bus = mk_bundle(32'h2000 + 32'(i + 2), 32'hC2 + 32'(i));
      check("stream_obus", q.out_bus, mk_bundle(32'h2000 + 32'(i), 32'hC0 + 32'(i)));
      step();
      check("stream_count", 64'(q.count), 64'd2);
    end
    check("stream_tail", q.out_bus, mk_bundle(32'h200a, 32'hCA));
    q.out_allowin = 1'b0;
    q.in_bus = mk_bundle(32'h3000, 32'hD0);
    step();
    check("preflush_count", 64'(q.count), 64'd3);

    // Flush with concurrent push (and a pop request that must not count)
    q.flush       = 1'b1;
    q.out_allowin = 1'b1;
    q.in_bus      = mk_bundle(32'h4000, 32'hBB);
    step();
    q.flush = 1'b0;
    check("flush_count",   64'(q.count), 64'd0);
    check("flush_ovalid",  64'(q.out_valid), 64'd0);
    check("flush_allowin", 64'(q.in_allowin), 64'd1);
    q.out_allowin = 1'b0;
    q.in_bus = mk_bundle(32'h5000, 32'hCC);
    step();
    q.in_valid = 1'b0;
    check("postflush_count", 64'(q.count), 64'd1);
    check("postflush_obus",  q.out_bus, mk_bundle(32'h5000, 32'hCC));
    q.out_allowin = 1'b1;
    step();
    check("postflush_drain", 64'(q.count), 64'd0);

    // Asynchronous reset mid-stream
    q.out_allowin = 1'b0;
    q.in_valid    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q.in_bus = mk_bundle(32'h6000 + 32'(i), 32'hE0 + 32'(i));
      step();
    end
    q.in_valid = 1'b0;
    check("arst_pre_count", 64'(q.count), 64'd2);
    #2 resetn = 1'b0;
    #1;
    check("arst_count",  64'(q.count), 64'd0);
    check("arst_ovalid", 64'(q.out_valid), 64'd0);
    check("arst_obus",   q.out_bus, 64'd0);
    #2 resetn = 1'b1;
    step();
    q.in_valid = 1'b1;
    q.in_bus   = mk_bundle(32'h7000, 32'hF0);
    step();
    q.in_valid = 1'b0;
    check("resume_count", 64'(q.count), 64'd1);
    check("resume_obus",  q.out_bus, mk_bundle(32'h7000, 32'hF0));
    q.out_allowin = 1'b1;
    step();
    check("resume_drain", 64'(q.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised, multi-entry successor to the single-register fetch-to-decode handoff.
- Sits between the IF and ID stages and decouples them with a DEPTH-entry circular FIFO of fetch bundles (pc + inst), so that short stalls in ID do not stall fetch.
- Uses the same valid/allowin handshake as the other pipeline stages.
- Supports a flush on taken branch or redirect that discards every queued and incoming bundle in one cycle.

Parameters:
- BUS_W, 64, width of one fetch bundle (pc[63:32], inst[31:0] by default).
- DEPTH, 4, number of entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  IF presents a bundle (fs_to_ds_valid equivalent).
- in_bus  input  BUS_W  bundle from IF.
- in_allowin  output  1  queue can accept a bundle this cycle.
- out_valid  output  1  head bundle valid towards ID.
- out_bus  output  BUS_W  head bundle.
- out_allowin  input  1  ID accepts the head this cycle (ds_allowin equivalent).
- flush  input  1  discard all contents (branch taken / redirect).
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (resetn=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0.
  - All entries cleared to 0.
  - out_valid=0, out_bus=0, in_allowin=1.
- Handshake:
  - push = in_valid & in_allowin & ~flush.
  - pop = out_valid & out_allowin & ~flush.
- Readiness:
  - in_allowin = (count != DEPTH).
  - No pass-through when full; this keeps in_allowin free of any combinational path from out_allowin.
- Output:
  - out_valid = (count != 0).
  - out_bus = entry[rd_ptr], a combinational read of registered storage.
- Latency: a bundle pushed in cycle N is visible on out_bus with out_valid=1 in cycle N+1 at the earliest. There is no same-cycle bypass.
- Push: entry[wr_ptr] <= in_bus; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH by natural truncation of a log2(DEPTH)-bit pointer.
- Pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged, and both pointers advance.
- Full (count==DEPTH): in_allowin=0; a pop in that cycle frees a slot for the next cycle only.
- Empty (count==0): out_valid=0; out_bus shows the stale entry at rd_ptr, which ID must ignore.
- Flush (has priority over everything):
  - Next cycle: rd_ptr=wr_ptr=0, count=0, out_valid=0.
  - An in_valid bundle offered in the flush cycle is dropped, and no pop is reported that cycle.
  - Entries themselves are not cleared.
- Flush during reset: reset dominates.
- Reset asserted mid-operation: all state clears immediately; in-flight bundles are lost.
- Pointer and count arithmetic are unsigned; count never exceeds DEPTH or goes below 0, because push is blocked when full and pop when empty.

Decomposition:
- Shared pipeline package: FS_TO_DS_BUS_W=64 constant, and bundle field offsets (PC_MSB=63, PC_LSB=32, INST_MSB=31, INST_LSB=0).
- No sub-module: the storage array, pointers and counter live in inst_queue.
- The top level instantiates inst_queue between IF_stage and ID_stage with DEPTH from a top-level parameter.

Test Plan:
- Reset then idle:
  - Release resetn with in_valid=0.
  - Expect count=0, out_valid=0, in_allowin=1, out_bus=0.
- Fill to full with ID stalled:
  - Push pc=0x1c000000..0x1c00000c, inst=0xA0..0xA3, with out_allowin=0.
  - Expect count 1,2,3,4, then in_allowin=0; a 5th in_valid is not accepted and count stays 4.
- Drain in order:
  - From full, set out_allowin=1 and in_valid=0.
  - Expect out_bus insts 0xA0,0xA1,0xA2,0xA3 on successive cycles, then out_valid=0 and count=0.
- Simultaneous push and pop with pointer wrap:
  - At count=2, run 10 cycles of in_valid=1 and out_allowin=1 with incrementing inst.
  - Expect count constant at 2, strict FIFO order, and pointers wrapping past DEPTH-1 with no lost or duplicated bundle.
- Flush with concurrent push:
  - At count=3, assert flush together with in_valid=1 (inst=0xBB).
  - Next cycle expect count=0 and out_valid=0.
  - 0xBB never appears; the next push (0xCC) is the first popped.
- Asynchronous reset mid-stream:
  - At count=2, drop resetn between clock edges.
  - Expect count=0 and out_valid=0 before the next rising edge; normal operation resumes after release.
